// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline control blocks.
package arm_pkg;

    localparam int unsigned REG_ADDR_LEN  = 4;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned WAIT_CNT_W    = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StError = 2'd2
    } mem_state_e;

    // True when a writing instruction targets a register read by the ID instruction.
    function automatic logic raw_hit(
        input logic [REG_ADDR_LEN-1:0] dest,
        input logic                    wb_en,
        input logic [REG_ADDR_LEN-1:0] src1,
        input logic [REG_ADDR_LEN-1:0] src2,
        input logic                    two_src
    );
        return wb_en && ((dest == src1) || (two_src && (dest == src2)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the hazard/stall controller.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = arm_pkg::CNT_W_DEFAULT
) ();

    logic [arm_pkg::REG_ADDR_LEN-1:0] src1;
    logic [arm_pkg::REG_ADDR_LEN-1:0] src2;
    logic                             two_src;
    logic [arm_pkg::REG_ADDR_LEN-1:0] EXE_dest;
    logic                             EXE_WB_EN;
    logic                             EXE_MEM_R_EN;
    logic [arm_pkg::REG_ADDR_LEN-1:0] MEM_dest;
    logic                             MEM_WB_EN;
    logic                             Branch_taken;
    logic                             mem_req;
    logic                             mem_ready;
    logic                             hazard;
    logic                             freeze;
    logic                             flush;
    logic                             mem_stall;
    logic                             mem_error;
    logic [CNT_W-1:0]                 stall_cycles;
    logic [CNT_W-1:0]                 flush_events;

    // Pipeline side
    modport master (
        output src1, src2, two_src, EXE_dest, EXE_WB_EN, EXE_MEM_R_EN,
               MEM_dest, MEM_WB_EN, Branch_taken, mem_req, mem_ready,
        input  hazard, freeze, flush, mem_stall, mem_error, stall_cycles, flush_events
    );

    // Controller side
    modport slave (
        input  src1, src2, two_src, EXE_dest, EXE_WB_EN, EXE_MEM_R_EN,
               MEM_dest, MEM_WB_EN, Branch_taken, mem_req, mem_ready,
        output hazard, freeze, flush, mem_stall, mem_error, stall_cycles, flush_events
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register; clear wins over enable.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection, branch flush and data-memory wait-state control.
module hazard_stall_ctrl
    import arm_pkg::*;
#(
    parameter bit          FORWARD_EN  = 1'b0,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] TimeoutVal = WAIT_CNT_W'(MEM_TIMEOUT);

    mem_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_error_q, mem_error_d;

    logic                    hazard_raw;
    logic                    mem_stall;
    logic                    hazard;
    logic                    freeze;
    logic                    flush;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        flush_cnt;

    // RAW detect: with forwarding only a load in EXE forces a bubble.
    always_comb begin
        hazard_raw = 1'b0;
        if (FORWARD_EN) begin
            hazard_raw = bus.EXE_MEM_R_EN &&
                         raw_hit(bus.EXE_dest, bus.EXE_WB_EN, bus.src1, bus.src2, bus.two_src);
        end else begin
            hazard_raw = raw_hit(bus.EXE_dest, bus.EXE_WB_EN, bus.src1, bus.src2, bus.two_src) ||
                         raw_hit(bus.MEM_dest, bus.MEM_WB_EN, bus.src1, bus.src2, bus.two_src);
        end
    end

    // Memory FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Memory FSM next state; ERROR is only left through reset.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d    = StWait;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end
            end
            StWait: begin
                if (bus.mem_ready) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TimeoutVal) begin
                    state_d     = StError;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Prioritised pipeline controls: memory stall, then branch flush, then RAW bubble.
    always_comb begin
        mem_stall = bus.mem_req && !bus.mem_ready && (state_q != StError);
        hazard    = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        if (mem_stall) begin
            freeze = 1'b1;
        end else if (bus.Branch_taken) begin
            flush = 1'b1;
        end else if (hazard_raw) begin
            hazard = 1'b1;
            freeze = 1'b1;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (freeze),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (flush),
        .cnt_o (flush_cnt)
    );

    assign bus.hazard       = hazard;
    assign bus.freeze       = freeze;
    assign bus.flush        = flush;
    assign bus.mem_stall    = mem_stall;
    assign bus.mem_error    = mem_error_q;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench: two controller configurations driven with identical stimulus and
// compared every cycle against a behavioural model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src1 = '0, src2 = '0, EXE_dest = '0, MEM_dest = '0;
    logic       two_src = 1'b0, EXE_WB_EN = 1'b0, EXE_MEM_R_EN = 1'b0, MEM_WB_EN = 1'b0;
    logic       Branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

    always #5 clk = ~clk;

    // A: no forwarding, long timeout, wide counters. B: forwarding, timeout 4, 4-bit counters.
    hazard_stall_ctrl_if #(.CNT_W(16)) if_a ();
    hazard_stall_ctrl_if #(.CNT_W(4))  if_b ();

    hazard_stall_ctrl #(
        .FORWARD_EN  (1'b0),
        .MEM_TIMEOUT (255),
        .CNT_W       (16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    hazard_stall_ctrl #(
        .FORWARD_EN  (1'b1),
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    assign if_a.src1 = src1;                 assign if_b.src1 = src1;
    assign if_a.src2 = src2;                 assign if_b.src2 = src2;
    assign if_a.two_src = two_src;           assign if_b.two_src = two_src;
    assign if_a.EXE_dest = EXE_dest;         assign if_b.EXE_dest = EXE_dest;
    assign if_a.EXE_WB_EN = EXE_WB_EN;       assign if_b.EXE_WB_EN = EXE_WB_EN;
    assign if_a.EXE_MEM_R_EN = EXE_MEM_R_EN; assign if_b.EXE_MEM_R_EN = EXE_MEM_R_EN;
    assign if_a.MEM_dest = MEM_dest;         assign if_b.MEM_dest = MEM_dest;
    assign if_a.MEM_WB_EN = MEM_WB_EN;       assign if_b.MEM_WB_EN = MEM_WB_EN;
    assign if_a.Branch_taken = Branch_taken; assign if_b.Branch_taken = Branch_taken;
    assign if_a.mem_req = mem_req;           assign if_b.mem_req = mem_req;
    assign if_a.mem_ready = mem_ready;       assign if_b.mem_ready = mem_ready;

    int n_cmp = 0;
    int n_mis = 0;

    // Model configuration and state, index 0 = A, 1 = B.
    string nm   [2] = '{"A", "B"};
    bit    fwd  [2] = '{1'b0, 1'b1};
    int    tmo  [2] = '{255, 4};
    int    cmax [2] = '{65535, 15};
    int    waited [2];   // consecutive cycles spent waiting, 0 when not waiting
    bit    in_err [2];
    int    m_stall [2];
    int    m_flush [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit raw(input logic [3:0] d, input logic en);
        return en && (d == src1 || (two_src && d == src2));
    endfunction

    function automatic void model_outs(input int d, output bit h, output bit f,
                                       output bit fl, output bit ms);
        bit hr;
        if (fwd[d]) hr = EXE_MEM_R_EN && raw(EXE_dest, EXE_WB_EN);
        else        hr = raw(EXE_dest, EXE_WB_EN) || raw(MEM_dest, MEM_WB_EN);
        ms = mem_req && !mem_ready && !in_err[d];
        fl = !ms && Branch_taken;
        h  = !ms && !Branch_taken && hr;
        f  = ms || h;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            waited[d] = 0; in_err[d] = 1'b0; m_stall[d] = 0; m_flush[d] = 0;
        end
    endfunction

    // Compare every output of both DUTs against the model mid-cycle.
    task automatic settle();
        logic [31:0] g [2][7];
        bit h, f, fl, ms;
        @(negedge clk);
        g[0][0] = 32'(if_a.hazard);    g[1][0] = 32'(if_b.hazard);
        g[0][1] = 32'(if_a.freeze);    g[1][1] = 32'(if_b.freeze);
        g[0][2] = 32'(if_a.flush);     g[1][2] = 32'(if_b.flush);
        g[0][3] = 32'(if_a.mem_stall); g[1][3] = 32'(if_b.mem_stall);
        g[0][4] = 32'(if_a.mem_error); g[1][4] = 32'(if_b.mem_error);
        g[0][5] = 32'(if_a.stall_cycles); g[1][5] = 32'(if_b.stall_cycles);
        g[0][6] = 32'(if_a.flush_events); g[1][6] = 32'(if_b.flush_events);
        for (int d = 0; d < 2; d++) begin
            model_outs(d, h, f, fl, ms);
            check({nm[d], ".hazard"},       g[d][0], 32'(h));
            check({nm[d], ".freeze"},       g[d][1], 32'(f));
            check({nm[d], ".flush"},        g[d][2], 32'(fl));
            check({nm[d], ".mem_stall"},    g[d][3], 32'(ms));
            check({nm[d], ".mem_error"},    g[d][4], 32'(in_err[d]));
            check({nm[d], ".stall_cycles"}, g[d][5], 32'(m_stall[d]));
            check({nm[d], ".flush_events"}, g[d][6], 32'(m_flush[d]));
        end
    endtask

    // Clock edge plus model update from the inputs of the cycle just ended.
    task automatic tick();
        bit h, f, fl, ms;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                model_outs(d, h, f, fl, ms);
                if (f && m_stall[d] < cmax[d]) m_stall[d]++;
                if (fl && m_flush[d] < cmax[d]) m_flush[d]++;
                if (!in_err[d]) begin
                    if (waited[d] == 0) begin
                        if (mem_req && !mem_ready) waited[d] = 1;
                    end else if (mem_ready) begin
                        waited[d] = 0;
                    end else if (waited[d] == tmo[d]) begin
                        in_err[d] = 1'b1;
                        waited[d] = 0;
                    end else begin
                        waited[d]++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        src1 = '0; src2 = '0; EXE_dest = '0; MEM_dest = '0;
        two_src = 1'b0; EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0; MEM_WB_EN = 1'b0;
        Branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Initial reset: state is unknown before the first edge, so no checks yet.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        settle();
        check("reset A.mem_error", 32'(if_a.mem_error), 32'd0);
        check("reset B.stall_cycles", 32'(if_b.stall_cycles), 32'd0);
        tick();

        // RAW hazard without forwarding.
        EXE_WB_EN = 1'b1; EXE_dest = 4'd3; src1 = 4'd3;
        settle();
        check("raw A.hazard", 32'(if_a.hazard), 32'd1);
        check("raw A.freeze", 32'(if_a.freeze), 32'd1);
        tick();
        src1 = 4'd7; src2 = 4'd3; two_src = 1'b0;
        settle();
        check("one_src A.hazard", 32'(if_a.hazard), 32'd0);
        tick();

        // Load-use with forwarding.
        EXE_dest = 4'd5; src1 = 4'd9; src2 = 4'd5; two_src = 1'b1; EXE_MEM_R_EN = 1'b0;
        settle();
        check("nonload B.hazard", 32'(if_b.hazard), 32'd0);
        tick();
        EXE_MEM_R_EN = 1'b1;
        settle();
        check("loaduse B.hazard", 32'(if_b.hazard), 32'd1);
        tick();
        clear_inputs();

        // Three wait states.
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("wait A.mem_stall", 32'(if_a.mem_stall), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        check("ready A.mem_stall", 32'(if_a.mem_stall), 32'd0);
        tick();
        clear_inputs();
        settle();
        check("wait A.stall_cycles", 32'(if_a.stall_cycles), 32'd3);
        tick();

        // Priority: branch over hazard, memory stall over branch.
        EXE_WB_EN = 1'b1; EXE_dest = 4'd3; src1 = 4'd3; Branch_taken = 1'b1;
        settle();
        check("prio A.flush", 32'(if_a.flush), 32'd1);
        check("prio A.freeze", 32'(if_a.freeze), 32'd0);
        tick();
        mem_req = 1'b1;
        settle();
        check("prio A.flush_events", 32'(if_a.flush_events), 32'd1);
        check("memprio A.freeze", 32'(if_a.freeze), 32'd1);
        check("memprio A.flush", 32'(if_a.flush), 32'd0);
        tick();
        mem_ready = 1'b1;
        settle();
        tick();
        clear_inputs();

        // Watchdog on B.
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            tick();
        end
        settle();
        check("wdog B.mem_error", 32'(if_b.mem_error), 32'd1);
        check("wdog B.mem_stall", 32'(if_b.mem_stall), 32'd0);
        check("wdog A.mem_stall", 32'(if_a.mem_stall), 32'd1);
        tick();
        do_reset();
        mem_req = 1'b0;
        settle();
        check("rst B.mem_error", 32'(if_b.mem_error), 32'd0);
        check("rst B.stall_cycles", 32'(if_b.stall_cycles), 32'd0);
        tick();

        // Saturation of the 4-bit counter.
        EXE_dest = 4'd5; EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1; src1 = 4'd5;
        for (int i = 0; i < 20; i++) begin
            settle();
            tick();
        end
        clear_inputs();
        settle();
        check("sat B.stall_cycles", 32'(if_b.stall_cycles), 32'd15);
        check("nosat A.stall_cycles", 32'(if_a.stall_cycles), 32'd20);
        tick();

        // Randomised traffic with small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            src1         = 4'($urandom_range(0, 3));
            src2         = 4'($urandom_range(0, 3));
            EXE_dest     = 4'($urandom_range(0, 3));
            MEM_dest     = 4'($urandom_range(0, 3));
            two_src      = 1'($urandom);
            EXE_WB_EN    = 1'($urandom);
            EXE_MEM_R_EN = 1'($urandom);
            MEM_WB_EN    = 1'($urandom);
            Branch_taken = ($urandom_range(0, 5) == 0);
            mem_req      = 1'($urandom);
            mem_ready    = ($urandom_range(0, 2) == 0);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
